// File: rtl/insn_prefetcher_pkg.sv
// Shared prefetch types and the real-mode segment:offset address helper,
// also used by the load/store unit.
package insn_prefetcher_pkg;

  localparam int unsigned SEG_W   = 16;
  localparam int unsigned PHYS_W  = 20;
  localparam int unsigned WADDR_W = PHYS_W - 1;
  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_FETCH   = 2'd1,
    PF_PUSH    = 2'd2,
    PF_DISCARD = 2'd3
  } pf_state_e;

  // The carry out of bit 19 is dropped, so addresses wrap at 1 MiB.
  function automatic logic [PHYS_W-1:0] phys_addr(input logic [SEG_W-1:0] cs,
                                                  input logic [SEG_W-1:0] ip);
    logic [PHYS_W-1:0] seg_base;
    logic [PHYS_W-1:0] offset;
    seg_base = {cs, 4'b0000};
    offset   = {4'b0000, ip};
    return PHYS_W'(seg_base + offset);
  endfunction

endpackage

// File: rtl/insn_prefetcher_if.sv
// Prefetcher bus bundle: flush/redirect, memory read port and FIFO write port.
interface insn_prefetcher_if;
  import insn_prefetcher_pkg::*;

  logic               flush;
  logic [SEG_W-1:0]   new_cs;
  logic [SEG_W-1:0]   new_ip;

  logic               mem_access;
  logic               mem_ack;
  logic [WADDR_W-1:0] mem_address;
  logic [WORD_W-1:0]  mem_data;

  logic               fifo_wr_en;
  logic [BYTE_W-1:0]  fifo_wr_data;
  logic               fifo_nearly_full;
  logic               fifo_full;

  modport master (
    input  flush, new_cs, new_ip,
    input  mem_ack, mem_data,
    input  fifo_nearly_full, fifo_full,
    output mem_access, mem_address,
    output fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output flush, new_cs, new_ip,
    output mem_ack, mem_data,
    output fifo_nearly_full, fifo_full,
    input  mem_access, mem_address,
    input  fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/insn_prefetcher.sv
// Instruction prefetcher: reads 16-bit words at CS:IP and streams their valid
// bytes into the instruction FIFO, restarting at a new CS:IP on flush.
module insn_prefetcher
  import insn_prefetcher_pkg::*;
#(
  parameter logic [SEG_W-1:0] RESET_CS = 16'hffff,
  parameter logic [SEG_W-1:0] RESET_IP = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  insn_prefetcher_if.master bus
);

  localparam logic [PHYS_W-1:0] RESET_PHYS = phys_addr(RESET_CS, RESET_IP);

  pf_state_e          state_q, state_d;
  logic [SEG_W-1:0]   cs_q, cs_d;
  logic [SEG_W-1:0]   ip_q, ip_d;
  logic [WORD_W-1:0]  buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic               access_q, access_d;
  logic               push_c;
  logic [PHYS_W-1:0]  phys_c;

  assign phys_c = phys_addr(cs_q, ip_q);

  // State and datapath registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= PF_IDLE;
      cs_q     <= RESET_CS;
      ip_q     <= RESET_IP;
      buf_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= RESET_PHYS[PHYS_W-1:1];
      access_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      ip_q     <= ip_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      access_q <= access_d;
    end
  end

  // Next-state and push decision.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    ip_d    = ip_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    push_c  = 1'b0;

    case (state_q)
      PF_IDLE: begin
        // The address is captured here so it stays put for the whole bus cycle.
        if (!bus.flush && !bus.fifo_nearly_full) begin
          state_d = PF_FETCH;
          addr_d  = phys_c[PHYS_W-1:1];
        end
      end
      PF_FETCH: begin
        if (bus.mem_ack) begin
          state_d = PF_PUSH;
          buf_d   = bus.mem_data;
          cnt_d   = ip_q[0] ? CNT_W'(1) : CNT_W'(2);
        end
      end
      PF_PUSH: begin
        if (!bus.fifo_full) begin
          push_c = 1'b1;
          ip_d   = ip_q + SEG_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = PF_IDLE;
          end
        end
      end
      PF_DISCARD: begin
        if (bus.mem_ack) begin
          state_d = PF_IDLE;
        end
      end
      default: state_d = PF_IDLE;
    endcase

    // An outstanding bus cycle cannot be aborted, so it is drained in DISCARD.
    if (bus.flush) begin
      push_c = 1'b0;
      cs_d   = bus.new_cs;
      ip_d   = bus.new_ip;
      cnt_d  = '0;
      if (state_q == PF_FETCH) begin
        state_d = bus.mem_ack ? PF_IDLE : PF_DISCARD;
      end else if (state_q != PF_DISCARD) begin
        state_d = PF_IDLE;
      end
    end

    access_d = (state_d == PF_FETCH) || (state_d == PF_DISCARD);
  end

  assign bus.mem_access   = access_q;
  assign bus.mem_address  = addr_q;
  assign bus.fifo_wr_en   = push_c;
  assign bus.fifo_wr_data = ip_q[0] ? buf_q[WORD_W-1:BYTE_W] : buf_q[BYTE_W-1:0];

endmodule

// File: tb/tb_insn_prefetcher.sv
// Self-checking bench for insn_prefetcher: vector table of fetches plus
// hand-written flush, back-pressure and reset sequences.
module tb_insn_prefetcher;
  import insn_prefetcher_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  insn_prefetcher_if bus_if();

  insn_prefetcher #(
    .RESET_CS(16'hffff),
    .RESET_IP(16'h0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  typedef struct {
    logic        flush_en;
    logic [15:0] cs;
    logic [15:0] ip;
    logic [15:0] data;
    int          dly;
    logic [18:0] exp_addr;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and score any FIFO push seen there.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (bus_if.fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push: got byte %h expected no push", bus_if.fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("push_byte", 32'(bus_if.fifo_wr_data), 32'(e));
      end
    end
  endtask

  task automatic wait_access(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus_if.mem_access === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL access_timeout: got mem_access=0 for 50 cycles expected 1");
    end
  endtask

  // Hold the bus cycle for dly extra cycles, checking the request stays put.
  task automatic do_ack(input logic [15:0] d, input int dly, input logic [18:0] addr);
    for (int i = 0; i < dly; i++) begin
      step();
      check("access_held", 32'(bus_if.mem_access), 32'd1);
      check("addr_stable", 32'(bus_if.mem_address), 32'(addr));
    end
    bus_if.mem_ack  = 1'b1;
    bus_if.mem_data = d;
    step();
    bus_if.mem_ack  = 1'b0;
    bus_if.mem_data = 16'h0000;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    vec_t v;

    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 16'h34ea, 0, 19'h7fff8, 2, 8'hea, 8'h34};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'h7788, 2, 19'h7fff9, 2, 8'h88, 8'h77};
    vecs[2] = '{1'b1, 16'h1000, 16'h0003, 16'hbbaa, 0, 19'h08001, 1, 8'hbb, 8'h00};
    vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h2211, 1, 19'h08002, 2, 8'h11, 8'h22};
    vecs[4] = '{1'b1, 16'h0000, 16'hffff, 16'h5a11, 0, 19'h07fff, 1, 8'h5a, 8'h00};
    vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'hc3d4, 3, 19'h00000, 2, 8'hd4, 8'hc3};
    vecs[6] = '{1'b1, 16'hffff, 16'h0010, 16'h0102, 1, 19'h00000, 2, 8'h02, 8'h01};
    vecs[7] = '{1'b1, 16'h1234, 16'h5678, 16'habcd, 0, 19'h0bcdc, 2, 8'hcd, 8'hab};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 16'h9f8e, 2, 19'h0bcdd, 2, 8'h8e, 8'h9f};

    reset                   = 1'b0;
    bus_if.flush            = 1'b0;
    bus_if.new_cs           = 16'h0000;
    bus_if.new_ip           = 16'h0000;
    bus_if.mem_ack          = 1'b0;
    bus_if.mem_data         = 16'h0000;
    bus_if.fifo_nearly_full = 1'b1;
    bus_if.fifo_full        = 1'b0;

    repeat (3) step();
    check("reset_mem_access", 32'(bus_if.mem_access), 32'd0);
    check("reset_fifo_wr_en", 32'(bus_if.fifo_wr_en), 32'd0);
    reset = 1'b1;

    // Table of single-word fetches; nearly_full is raised mid-fetch and must not stall it.
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.flush_en) begin
        bus_if.flush  = 1'b1;
        bus_if.new_cs = v.cs;
        bus_if.new_ip = v.ip;
        step();
        bus_if.flush  = 1'b0;
      end
      bus_if.fifo_nearly_full = 1'b0;
      wait_access(ok);
      if (ok) begin
        check("vec_addr", 32'(bus_if.mem_address), 32'(v.exp_addr));
        bus_if.fifo_nearly_full = 1'b1;
        exp_q.push_back(v.b0);
        if (v.nbytes == 2) exp_q.push_back(v.b1);
        do_ack(v.data, v.dly, v.exp_addr);
        check("first_push_latency", 32'(exp_q.size()), 32'(v.nbytes - 1));
        drain();
      end
    end

    // Flush while a fetch is outstanding: bus cycle completes, data dropped.
    bus_if.fifo_nearly_full = 1'b0;
    wait_access(ok);
    check("pre_flush_addr", 32'(bus_if.mem_address), 32'h0bcde);
    bus_if.flush  = 1'b1;
    bus_if.new_cs = 16'h2000;
    bus_if.new_ip = 16'h0000;
    step();
    bus_if.flush  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("discard_access", 32'(bus_if.mem_access), 32'd1);
      check("discard_addr", 32'(bus_if.mem_address), 32'h0bcde);
    end
    bus_if.mem_ack  = 1'b1;
    bus_if.mem_data = 16'hffff;
    step();
    bus_if.mem_ack  = 1'b0;
    bus_if.mem_data = 16'h0000;
    check("discard_end_access", 32'(bus_if.mem_access), 32'd0);
    wait_access(ok);
    check("post_flush_addr", 32'(bus_if.mem_address), 32'h10000);
    bus_if.fifo_nearly_full = 1'b1;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    do_ack(16'h4433, 0, 19'h10000);
    drain();

    // Nearly-full holds the prefetcher idle.
    for (int i = 0; i < 10; i++) begin
      step();
      check("nearly_full_idle", 32'(bus_if.mem_access), 32'd0);
    end
    bus_if.fifo_nearly_full = 1'b0;
    step();
    check("space_to_access", 32'(bus_if.mem_access), 32'd1);
    check("space_addr", 32'(bus_if.mem_address), 32'h10001);
    bus_if.fifo_nearly_full = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    do_ack(16'h6655, 0, 19'h10001);
    drain();

    // FIFO full after the low byte: the high byte waits and is pushed once.
    bus_if.fifo_nearly_full = 1'b0;
    wait_access(ok);
    check("full_seq_addr", 32'(bus_if.mem_address), 32'h10002);
    bus_if.fifo_nearly_full = 1'b1;
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h88);
    do_ack(16'h8877, 0, 19'h10002);
    check("full_first_byte", 32'(exp_q.size()), 32'd1);
    bus_if.fifo_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("full_no_push", 32'(bus_if.fifo_wr_en), 32'd0);
    end
    bus_if.fifo_full = 1'b0;
    step();
    check("full_resume", 32'(exp_q.size()), 32'd0);
    repeat (3) step();

    // Reset in the middle of a fetch.
    bus_if.fifo_nearly_full = 1'b0;
    wait_access(ok);
    check("pre_reset_addr", 32'(bus_if.mem_address), 32'h10003);
    reset = 1'b0;
    step();
    check("reset_drops_access", 32'(bus_if.mem_access), 32'd0);
    reset = 1'b1;
    wait_access(ok);
    check("reset_restart_addr", 32'(bus_if.mem_address), 32'h7fff8);
    bus_if.fifo_nearly_full = 1'b1;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    do_ack(16'h1234, 0, 19'h7fff8);
    drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/insn_prefetcher.md
Name: insn_prefetcher

Overview:
Instruction prefetch stage directly upstream of the instruction byte FIFO feeding the decoder and immediate reader. It fetches 16-bit words from memory at CS:IP and pushes the valid bytes into the FIFO one per cycle. It pauses while the FIFO has fewer than two free slots. On flush (branch, interrupt, far jump) it discards buffered bytes and restarts at a new CS:IP.

Parameters:
RESET_CS, 16'hffff, CS value loaded on reset.
RESET_IP, 16'h0000, IP value loaded on reset.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
flush  input  1  discard state and load new_cs/new_ip
new_cs  input  16  code segment loaded on flush
new_ip  input  16  instruction pointer loaded on flush
mem_access  output  1  memory read request, held until mem_ack
mem_ack  input  1  read complete, mem_data valid this cycle
mem_address  output  19  word address [19:1] of the read
mem_data  input  16  read data, little-endian
fifo_wr_en  output  1  push fifo_wr_data into the instruction FIFO
fifo_wr_data  output  8  byte to push
fifo_nearly_full  input  1  fewer than 2 free FIFO slots
fifo_full  input  1  no free FIFO slot

Behaviour:
- Reset (reset==0 at a clock edge) overrides everything, including flush: state=IDLE, cs=RESET_CS, ip=RESET_IP, mem_access=0, fifo_wr_en=0, byte buffer empty.
- Physical address = {cs,4'b0} + {4'b0,ip}, 20 bits, carry dropped (wraps at 1 MiB). mem_address = phys[19:1].
- IP increments by 1 per byte pushed, 16-bit wrap (ffff->0000). CS never changes except on flush or reset.
- States:
  - IDLE: if !flush && !fifo_nearly_full, go to FETCH. mem_access=1 from the next cycle.
  - FETCH: mem_access=1, and mem_address stays stable. On mem_ack, latch mem_data and go to PUSH; mem_access=0 from the next cycle. Byte count is 1 if ip[0] (high byte only), else 2 (low byte then high byte).
  - PUSH: fifo_wr_en = !fifo_full && !flush. fifo_wr_data is the current byte. On each push, ip++ and the count decrements. After the last byte, go to IDLE.
  - DISCARD: mem_access=1 until mem_ack. mem_data is ignored, then go to IDLE.
- Minimum latency from space available to the first push: IDLE decision in cycle 0, mem_access in cycle 1, ack in cycle k, fifo_wr_en in cycle k+1.
- flush takes priority over all other events:
  - cs/ip load new values at that edge and the byte buffer is cleared.
  - fifo_wr_en=0 in the flush cycle. The FIFO is flushed externally by the same signal.
  - flush in FETCH without mem_ack: go to DISCARD, because a bus cycle cannot be aborted.
  - flush coincident with mem_ack: drop the data and go to IDLE.
  - flush in PUSH or IDLE: go to IDLE.
  - flush in DISCARD: stay in DISCARD and load the new cs/ip.
- fifo_full while in PUSH: hold the byte and ip, with fifo_wr_en=0. Resume with the same byte when space frees.
- fifo_nearly_full has no effect once FETCH has started.

Decomposition:
- Shared package: prefetch state enum (IDLE, FETCH, PUSH, DISCARD) and a function phys_addr(cs, ip) returning 20 bits. The function is reused by the load/store unit.
- No sub-module needed: single module, around 150–200 lines.

Test Plan:
1. Release reset with mem_data=16'h34ea, 1-cycle ack -> mem_address=19'h7fff8 (phys ffff0); fifo pushes ea then 34; ip=0002; next fetch at 19'h7fff9.
2. flush with new_cs=1000, new_ip=0003, mem_data=16'hbbaa -> mem_address=19'h08001; only bb pushed; ip=0004; next fetch at 19'h08002.
3. flush while FETCH is pending, ack 3 cycles later -> mem_access held until ack; no fifo_wr_en; then mem_access restarts at the new address.
4. fifo_nearly_full held 10 cycles in IDLE -> mem_access stays 0. Deassert -> mem_access=1 the next cycle.
5. cs=0000, ip=ffff, mem_data=16'h5a11 -> mem_address=19'h07fff; only 5a pushed; ip=0000; next mem_address=19'h00000.
6. fifo_full asserted after the first byte of a 2-byte word for 2 cycles -> fifo_wr_en=0 for those cycles, then the high byte is pushed once. Separately, reset asserted mid-FETCH -> mem_access=0 on the next cycle and cs/ip return to ffff/0000.
